// File: rtl/store_buffer_pkg.sv
// Shared definitions for the MEM-stage store path: access-size codes and the
// packed store entry held in the store buffer FIFO.
package store_buffer_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
  } store_entry_t;

  function automatic logic [3:0] half_lanes(input logic upper);
    return upper ? 4'b1100 : 4'b0011;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store request and data-memory signals of the store buffer; slave is the
// buffer itself, master is whoever drives the MEM stage and the memory port.
interface store_buffer_if;
  import store_buffer_pkg::*;

  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_ready;
  logic        st_fault;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic        mem_ready;
  logic        empty;

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_ready,
    output st_ready, st_fault, mem_valid, mem_addr, mem_wdata, mem_byteen, empty
  );

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_ready,
    input  st_ready, st_fault, mem_valid, mem_addr, mem_wdata, mem_byteen, empty
  );

endinterface

// File: rtl/store_buffer_packer.sv
// Narrows a register value to byte lanes for sb/sh/sw and flags misaligned or
// reserved-size requests. Purely combinational.
module store_packer
  import store_buffer_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  output logic [31:0] word_addr_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  byteen_o,
  output logic        fault_o
);

  // Lane replication and byte-enable selection per access size.
  always_comb begin
    word_addr_o = {addr_i[31:2], 2'b00};
    wdata_o     = 32'h0000_0000;
    byteen_o    = 4'b0000;
    fault_o     = 1'b0;
    case (size_i)
      SIZE_B: begin
        wdata_o  = {4{data_i[7:0]}};
        byteen_o = 4'b0001 << addr_i[1:0];
      end
      SIZE_H: begin
        wdata_o  = {2{data_i[15:0]}};
        byteen_o = half_lanes(addr_i[1]);
        fault_o  = addr_i[0];
      end
      SIZE_W: begin
        wdata_o  = data_i;
        byteen_o = 4'b1111;
        fault_o  = (addr_i[1:0] != 2'b00);
      end
      default: begin
        fault_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// MEM-stage store buffer: packs stores at enqueue and drains them in program
// order to data memory over a valid/ready handshake.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  store_entry_t     fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] pk_addr_s;
  logic [31:0] pk_wdata_s;
  logic [3:0]  pk_byteen_s;
  logic        pk_fault_s;
  logic        full_s;
  logic        empty_s;
  logic        enq_s;
  logic        deq_s;
  store_entry_t head_s;

  store_packer u_packer (
    .addr_i      (bus.st_addr),
    .data_i      (bus.st_data),
    .size_i      (bus.st_size),
    .word_addr_o (pk_addr_s),
    .wdata_o     (pk_wdata_s),
    .byteen_o    (pk_byteen_s),
    .fault_o     (pk_fault_s)
  );

  // Occupancy flags and handshake qualifiers; st_ready looks only at count.
  always_comb begin
    full_s  = (count_q == FULL_CNT);
    empty_s = (count_q == {CNT_W{1'b0}});
    enq_s   = bus.st_valid & ~full_s & ~pk_fault_s;
    deq_s   = ~empty_s & bus.mem_ready;
  end

  // Pointer and count next-state; power-of-two depth makes pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (deq_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({enq_s, deq_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, pointers and count; reset drops every pending entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (enq_s) begin
        fifo_q[wr_ptr_q] <= '{addr: pk_addr_s, wdata: pk_wdata_s, byteen: pk_byteen_s};
      end
    end
  end

  // Head presentation; data outputs read as zero whenever nothing is pending.
  always_comb begin
    head_s         = fifo_q[rd_ptr_q];
    bus.st_ready   = ~full_s;
    bus.st_fault   = bus.st_valid & pk_fault_s;
    bus.mem_valid  = ~empty_s;
    bus.empty      = empty_s;
    if (empty_s) begin
      bus.mem_addr   = 32'h0000_0000;
      bus.mem_wdata  = 32'h0000_0000;
      bus.mem_byteen = 4'b0000;
    end else begin
      bus.mem_addr   = head_s.addr;
      bus.mem_wdata  = head_s.wdata;
      bus.mem_byteen = head_s.byteen;
    end
  end

endmodule
